// File: rtl/reward_pkg.sv
// Shared types for the reward/packing stage: packet type codes, FSM states,
// and the internal source-select code used by reward_packer.
package reward_pkg;

  typedef enum logic [2:0] {
    PKT_HB      = 3'b000,
    PKT_CHE     = 3'b001,
    PKT_INV     = 3'b010,
    PKT_MR      = 3'b011,
    PKT_CHT     = 3'b100,
    PKT_DATA    = 3'b101,
    PKT_SOS     = 3'b110,
    PKT_INVALID = 3'b111
  } pkt_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_HB,
    SEL_INV,
    SEL_FWD,
    SEL_CH_INV,
    SEL_MR,
    SEL_CHT,
    SEL_OWN
  } sel_e;

  // BROADCAST_ID is all-ones at whatever word width the packer is built with.
  localparam logic BROADCAST_BIT = 1'b1;

endpackage

// File: rtl/reward_packer_if.sv
// Packed-packet output bus from reward_packer to the radio TX stage,
// with a valid/ready handshake.
interface reward_packer_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] rSourceID;
  logic [WORD_WIDTH-1:0] rSourceHops;
  logic [WORD_WIDTH-1:0] rQValue;
  logic [WORD_WIDTH-1:0] rEnergyLeft;
  logic [WORD_WIDTH-1:0] rDestinationID;
  logic [WORD_WIDTH-1:0] rChosenCH;
  logic [WORD_WIDTH-1:0] rHopsFromCH;
  logic [2:0]            rPacketType;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output rSourceID, rSourceHops, rQValue, rEnergyLeft, rDestinationID,
           rChosenCH, rHopsFromCH, rPacketType, r_valid,
    input  r_ready
  );

  modport slave (
    input  rSourceID, rSourceHops, rQValue, rEnergyLeft, rDestinationID,
           rChosenCH, rHopsFromCH, rPacketType, r_valid,
    output r_ready
  );
endinterface

// File: rtl/reward_timer.sv
// Single down-counting wait timer shared by the INV-wait (non-CH) and
// MR-wait (CH) phases; expire pulses on the cycle the count goes 1 -> 0.
module reward_timer #(
  parameter int unsigned TO_WIDTH = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                load,
  input  logic [TO_WIDTH-1:0] value,
  input  logic                cancel,
  output logic                expire
);

  logic [TO_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cancel) begin
      cnt_q <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TO_WIDTH'(1);
    end
  end

  // A load or cancel in the final cycle supersedes the expiry.
  assign expire = (cnt_q == TO_WIDTH'(1)) && !load && !cancel;

endmodule

// File: rtl/reward_packer.sv
// Node reward/packing stage: picks one outgoing packet per event, packs its
// header and offers it to TX. Optional SOS packing under `REWARD_SOS_EN.
module reward_packer
  import reward_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned INV_HOP_LIMIT = 4,
  parameter int unsigned INV_TIMEOUT   = 10,
  parameter int unsigned MR_TIMEOUT    = 10,
  parameter int unsigned TO_WIDTH      = 16,
  parameter int unsigned DROP_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fSourceHops,
  input  logic [WORD_WIDTH-1:0] fQValue,
  input  logic [WORD_WIDTH-1:0] fEnergyLeft,
  input  logic [WORD_WIDTH-1:0] fHopsFromCH,
  input  logic [WORD_WIDTH-1:0] fChosenCH,
  input  logic                  iAmDestination,
  input  logic                  iHaveData,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic                  role,
  input  logic                  low_E,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic [WORD_WIDTH-1:0] chosenHop,
  reward_packer_if.master       tx,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_count
);

  localparam logic [WORD_WIDTH-1:0] BROADCAST_ID = {WORD_WIDTH{BROADCAST_BIT}};
  localparam logic [WORD_WIDTH-1:0] HOP_LIMIT_W  = WORD_WIDTH'(INV_HOP_LIMIT);

  typedef struct packed {
    pkt_type_e             typ;
    logic [WORD_WIDTH-1:0] src_id;
    logic [WORD_WIDTH-1:0] src_hops;
    logic [WORD_WIDTH-1:0] q_value;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] dest_id;
    logic [WORD_WIDTH-1:0] chosen_ch;
    logic [WORD_WIDTH-1:0] hops_ch;
  } pkt_t;

  localparam pkt_t PKT_RESET = '{typ: PKT_INVALID, default: '0};

  function automatic logic [WORD_WIDTH-1:0] sat_inc(input logic [WORD_WIDTH-1:0] v);
    return (&v) ? v : v + WORD_WIDTH'(1);
  endfunction

  state_e                state_q, state_d;
  pkt_t                  pkt_q, pkt_d, pkt_new;
  sel_e                  sel;
  logic                  hb_lock_q, hb_lock_d;
  logic                  ch_inv_pend_q, ch_inv_pend_d;
  logic                  mr_pend_q, mr_pend_d;
  logic                  cht_pend_q, cht_pend_d;
  logic                  role_q;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;

  logic                  hb_hit, inv_hit, fwd_hit;
  logic                  role_rise, role_fall;
  logic                  tmr_load, tmr_cancel, tmr_expire;
  logic [TO_WIDTH-1:0]   tmr_value;
  logic                  sos_fwd, sos_own;

`ifdef REWARD_SOS_EN
  assign sos_fwd = (fPacketType == PKT_SOS) || low_E;
  assign sos_own = low_E;
`else
  logic unused_low_e;
  assign unused_low_e = low_E;
  assign sos_fwd      = 1'b0;
  assign sos_own      = 1'b0;
`endif

  // Event qualifiers; in SEND these same conditions feed the drop counter.
  assign hb_hit  = en && (fPacketType == PKT_HB) && !hb_lock_q;
  assign inv_hit = en && (fPacketType == PKT_INV) && (fHopsFromCH < HOP_LIMIT_W);
  assign fwd_hit = en && ((fPacketType == PKT_DATA) || (fPacketType == PKT_SOS)) && iAmDestination;

  assign role_rise = role && !role_q;
  assign role_fall = !role && role_q;

  always_comb begin
    state_d = state_q;
    sel     = SEL_NONE;
    case (state_q)
      IDLE: begin
        if (hb_hit)             sel = SEL_HB;
        else if (inv_hit)       sel = SEL_INV;
        else if (fwd_hit)       sel = SEL_FWD;
        else if (ch_inv_pend_q) sel = SEL_CH_INV;
        else if (mr_pend_q)     sel = SEL_MR;
        else if (cht_pend_q)    sel = SEL_CHT;
        else if (iHaveData)     sel = SEL_OWN;
        if (sel != SEL_NONE) state_d = SEND;
      end
      SEND: if (tx.r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_new = '0;
    case (sel)
      SEL_HB: begin
        pkt_new.typ      = PKT_HB;
        pkt_new.src_id   = myNodeID;
        pkt_new.src_hops = sat_inc(fSourceHops);
        pkt_new.dest_id  = BROADCAST_ID;
      end
      SEL_INV: begin
        pkt_new.typ     = PKT_INV;
        pkt_new.src_id  = fSourceID;
        pkt_new.q_value = fQValue;
        pkt_new.hops_ch = sat_inc(fHopsFromCH);
        pkt_new.dest_id = BROADCAST_ID;
      end
      SEL_FWD: begin
        pkt_new.typ       = sos_fwd ? PKT_SOS : PKT_DATA;
        pkt_new.src_id    = fSourceID;
        pkt_new.src_hops  = fSourceHops;
        pkt_new.q_value   = fQValue;
        pkt_new.energy    = fEnergyLeft;
        pkt_new.chosen_ch = fChosenCH;
        pkt_new.hops_ch   = fHopsFromCH;
        pkt_new.dest_id   = chosenHop;
      end
      SEL_CH_INV: begin
        pkt_new.typ     = PKT_INV;
        pkt_new.src_id  = myNodeID;
        pkt_new.q_value = myQValue;
        pkt_new.hops_ch = WORD_WIDTH'(1);
        pkt_new.dest_id = BROADCAST_ID;
      end
      SEL_MR: begin
        pkt_new.typ       = PKT_MR;
        pkt_new.src_id    = myNodeID;
        pkt_new.src_hops  = hopsFromSink;
        pkt_new.q_value   = myQValue;
        pkt_new.energy    = myEnergy;
        pkt_new.chosen_ch = chosenCH;
        pkt_new.hops_ch   = hopsFromCH;
        pkt_new.dest_id   = chosenCH;
      end
      SEL_CHT: begin
        pkt_new.typ     = PKT_CHT;
        pkt_new.src_id  = myNodeID;
        pkt_new.q_value = myQValue;
        pkt_new.dest_id = BROADCAST_ID;
      end
      SEL_OWN: begin
        pkt_new.typ      = sos_own ? PKT_SOS : PKT_DATA;
        pkt_new.src_id   = myNodeID;
        pkt_new.src_hops = hopsFromSink;
        pkt_new.q_value  = myQValue;
        pkt_new.energy   = myEnergy;
        pkt_new.dest_id  = chosenHop;
      end
      default: pkt_new = '0;
    endcase
    pkt_d = (sel != SEL_NONE) ? pkt_new : pkt_q;
  end

  // Role rising edge re-arms the timer for the MR wait; any role edge kills
  // whatever wait was running. A fresh load always wins over the cancel.
  assign tmr_load   = role_rise || ((sel == SEL_HB) && !role);
  assign tmr_value  = role_rise ? TO_WIDTH'(MR_TIMEOUT) : TO_WIDTH'(INV_TIMEOUT);
  assign tmr_cancel = role_rise || role_fall;

  reward_timer #(
    .TO_WIDTH(TO_WIDTH)
  ) u_timer (
    .clk    (clk),
    .nrst   (nrst),
    .load   (tmr_load),
    .value  (tmr_value),
    .cancel (tmr_cancel),
    .expire (tmr_expire)
  );

  always_comb begin
    hb_lock_d     = hb_lock_q;
    ch_inv_pend_d = ch_inv_pend_q;
    mr_pend_d     = mr_pend_q;
    cht_pend_d    = cht_pend_q;
    drop_d        = drop_q;

    if (en && (fPacketType == PKT_DATA)) hb_lock_d = 1'b0;
    if (sel == SEL_HB)                   hb_lock_d = 1'b1;

    if (sel == SEL_CH_INV || role_fall) ch_inv_pend_d = 1'b0;
    if (role_rise)                      ch_inv_pend_d = 1'b1;

    if (sel == SEL_MR || role_rise) mr_pend_d = 1'b0;
    if (tmr_expire && !role)        mr_pend_d = 1'b1;

    if (sel == SEL_CHT || role_fall) cht_pend_d = 1'b0;
    if (tmr_expire && role)          cht_pend_d = 1'b1;

    if ((state_q == SEND) && (hb_hit || inv_hit || fwd_hit) && !(&drop_q))
      drop_d = drop_q + DROP_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      pkt_q         <= PKT_RESET;
      hb_lock_q     <= 1'b0;
      ch_inv_pend_q <= 1'b0;
      mr_pend_q     <= 1'b0;
      cht_pend_q    <= 1'b0;
      role_q        <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      pkt_q         <= pkt_d;
      hb_lock_q     <= hb_lock_d;
      ch_inv_pend_q <= ch_inv_pend_d;
      mr_pend_q     <= mr_pend_d;
      cht_pend_q    <= cht_pend_d;
      role_q        <= role;
      drop_q        <= drop_d;
    end
  end

  assign tx.r_valid        = (state_q == SEND);
  assign tx.rPacketType    = pkt_q.typ;
  assign tx.rSourceID      = pkt_q.src_id;
  assign tx.rSourceHops    = pkt_q.src_hops;
  assign tx.rQValue        = pkt_q.q_value;
  assign tx.rEnergyLeft    = pkt_q.energy;
  assign tx.rDestinationID = pkt_q.dest_id;
  assign tx.rChosenCH      = pkt_q.chosen_ch;
  assign tx.rHopsFromCH    = pkt_q.hops_ch;

  assign busy       = (state_q != IDLE);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_reward_packer.sv
// Scoreboard bench for reward_packer: directed events push expected packets,
// a negedge monitor pops and compares on every TX handshake.
module tb_reward_packer;
  import reward_pkg::*;

  localparam int unsigned W = 16;
`ifdef REWARD_SOS_EN
  localparam logic [2:0] T_LOWE = 3'b110;
`else
  localparam logic [2:0] T_LOWE = 3'b101;
`endif

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   fPacketType = '0;
  logic [W-1:0] fSourceID = '0, fSourceHops = '0, fQValue = '0, fEnergyLeft = '0;
  logic [W-1:0] fHopsFromCH = '0, fChosenCH = '0;
  logic         iAmDestination = 1'b0, iHaveData = 1'b0, role = 1'b0, low_E = 1'b0;
  logic [W-1:0] myNodeID = 16'h0011, hopsFromSink = 16'h0002;
  logic [W-1:0] myQValue = 16'h0500, myEnergy = 16'h0700;
  logic [W-1:0] chosenCH = 16'h0022, hopsFromCH = 16'h0003, chosenHop = 16'h0033;
  logic         busy;
  logic [7:0]   drop_count;

  reward_packer_if #(.WORD_WIDTH(W)) tx();

  reward_packer #(
    .WORD_WIDTH(W), .INV_HOP_LIMIT(4), .INV_TIMEOUT(10), .MR_TIMEOUT(10),
    .TO_WIDTH(16), .DROP_WIDTH(8)
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .fPacketType(fPacketType),
    .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fQValue(fQValue),
    .fEnergyLeft(fEnergyLeft), .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH),
    .iAmDestination(iAmDestination), .iHaveData(iHaveData),
    .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
    .myEnergy(myEnergy), .role(role), .low_E(low_E), .chosenCH(chosenCH),
    .hopsFromCH(hopsFromCH), .chosenHop(chosenHop), .tx(tx.master),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   typ;
    logic [W-1:0] src, hops, q, e, dest, ch, hfc;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  function automatic exp_t mk(input logic [2:0] t,
                              input logic [W-1:0] src, hops, q, e, dest, ch, hfc);
    exp_t r;
    r.typ = t; r.src = src; r.hops = hops; r.q = q; r.e = e;
    r.dest = dest; r.ch = ch; r.hfc = hfc;
    return r;
  endfunction

  exp_t got, want;
  always @(negedge clk) begin
    if (nrst && tx.r_valid && tx.r_ready) begin
      got.typ = tx.rPacketType;   got.src = tx.rSourceID;
      got.hops = tx.rSourceHops;  got.q = tx.rQValue;
      got.e = tx.rEnergyLeft;     got.dest = tx.rDestinationID;
      got.ch = tx.rChosenCH;      got.hfc = tx.rHopsFromCH;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pkt got=%h required=none", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          mismatched++;
          $display("FAIL pkt got=%h required=%h", got, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pulse_en(input logic [2:0] t,
                          input logic [W-1:0] src, hops, q, e, hfc, ch,
                          input logic me);
    fPacketType = t; fSourceID = src; fSourceHops = hops; fQValue = q;
    fEnergyLeft = e; fHopsFromCH = hfc; fChosenCH = ch; iAmDestination = me;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout got=%0d_pending required=0", name, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tx.r_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(tx.r_valid), 32'd0);
    check("rst_type", 32'(tx.rPacketType), 32'd7);
    check("rst_hops", 32'(tx.rSourceHops), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    nrst = 1'b1;
    tick();

    // HB ripple, locked HB, then MR after the INV wait
    sb.push_back(mk(3'b000, 16'h0011, 16'h0004, '0, '0, 16'hFFFF, '0, '0));
    pulse_en(3'b000, 16'h0099, 16'h0003, '0, '0, '0, '0, 1'b0);
    check("hb_latency", 32'(tx.r_valid), 32'd1);
    tick();
    pulse_en(3'b000, 16'h0099, 16'h0003, '0, '0, '0, '0, 1'b0);
    check("hb_locked_none", 32'(tx.r_valid), 32'd0);
    sb.push_back(mk(3'b011, 16'h0011, 16'h0002, 16'h0500, 16'h0700,
                    16'h0022, 16'h0022, 16'h0003));
    n = 2;
    while (!tx.r_valid && n < 30) begin
      tick();
      n++;
    end
    compared++;
    if (n < 10 || n > 11) begin
      mismatched++;
      $display("FAIL mr_delay got=%0d required=10..11", n);
    end
    wait_drain("mr", 5);

    // INV ripple near and beyond the hop limit
    sb.push_back(mk(3'b010, 16'h0044, '0, 16'h0123, '0, 16'hFFFF, '0, 16'h0004));
    pulse_en(3'b010, 16'h0044, '0, 16'h0123, '0, 16'h0003, '0, 1'b0);
    tick();
    pulse_en(3'b010, 16'h0045, '0, 16'h0123, '0, 16'h0004, '0, 1'b0);
    check("inv_far_none", 32'(tx.r_valid), 32'd0);
    wait_drain("inv", 5);

    // Back-pressure: drops while SEND holds the packet
    tx.r_ready = 1'b0;
    sb.push_back(mk(3'b101, 16'h0055, 16'h0007, 16'h0234, 16'h0AAA,
                    16'h0033, 16'h00CC, 16'h0002));
    pulse_en(3'b101, 16'h0055, 16'h0007, 16'h0234, 16'h0AAA, 16'h0002, 16'h00CC, 1'b1);
    check("send_busy", 32'(busy), 32'd1);
    pulse_en(3'b010, 16'h0001, '0, '0, '0, '0, '0, 1'b0);
    pulse_en(3'b000, 16'h0002, 16'h0001, '0, '0, '0, '0, 1'b0);
    pulse_en(3'b101, 16'h0003, '0, '0, '0, '0, '0, 1'b1);
    pulse_en(3'b001, 16'h0004, '0, '0, '0, '0, '0, 1'b0);
    check("drop_count", 32'(drop_count), 32'd3);
    check("hold_valid", 32'(tx.r_valid), 32'd1);
    check("hold_src", 32'(tx.rSourceID), 32'h0055);
    check("hold_hops", 32'(tx.rSourceHops), 32'h0007);
    check("hold_dest", 32'(tx.rDestinationID), 32'h0033);
    tx.r_ready = 1'b1;
    tick();
    check("handshake_idle", 32'(busy), 32'd0);
    wait_drain("drop", 5);

    // Forwarding with low energy, received SOS, not-for-me data
    low_E = 1'b1;
    sb.push_back(mk(T_LOWE, 16'h0066, 16'hFFFF, 16'h0001, 16'h0002,
                    16'h0033, 16'h0004, 16'h0003));
    pulse_en(3'b101, 16'h0066, 16'hFFFF, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
    low_E = 1'b0;
    tick();
    sb.push_back(mk(T_LOWE, 16'h0077, 16'h0001, 16'h0005, 16'h0006,
                    16'h0033, 16'h0008, 16'h0007));
    pulse_en(3'b110, 16'h0077, 16'h0001, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 1'b1);
    tick();
    pulse_en(3'b101, 16'h0078, '0, '0, '0, '0, '0, 1'b0);
    check("fwd_not_me_none", 32'(tx.r_valid), 32'd0);
    wait_drain("fwd", 5);

    // Saturating HB, then becoming CH: CH INV now, CHT after the MR wait
    sb.push_back(mk(3'b000, 16'h0011, 16'hFFFF, '0, '0, 16'hFFFF, '0, '0));
    sb.push_back(mk(3'b010, 16'h0011, '0, 16'h0500, '0, 16'hFFFF, '0, 16'h0001));
    sb.push_back(mk(3'b100, 16'h0011, '0, 16'h0500, '0, 16'hFFFF, '0, '0));
    pulse_en(3'b000, 16'h0012, 16'hFFFF, '0, '0, '0, '0, 1'b0);
    role = 1'b1;
    wait_drain("ch", 40);
    repeat (3) tick();
    check("ch_quiet", 32'(tx.r_valid), 32'd0);
    role = 1'b0;
    repeat (3) tick();
    check("role_fall_quiet", 32'(tx.r_valid), 32'd0);

    // Own data, normal and low energy
    sb.push_back(mk(3'b101, 16'h0011, 16'h0002, 16'h0500, 16'h0700, 16'h0033, '0, '0));
    iHaveData = 1'b1;
    tick();
    iHaveData = 1'b0;
    wait_drain("own", 5);
    sb.push_back(mk(T_LOWE, 16'h0011, 16'h0002, 16'h0500, 16'h0700, 16'h0033, '0, '0));
    low_E = 1'b1;
    iHaveData = 1'b1;
    tick();
    iHaveData = 1'b0;
    low_E = 1'b0;
    wait_drain("own_lowe", 5);

    // INV outranks own data in the same cycle; own data follows
    sb.push_back(mk(3'b010, 16'h0088, '0, 16'h0321, '0, 16'hFFFF, '0, 16'h0001));
    sb.push_back(mk(3'b101, 16'h0011, 16'h0002, 16'h0500, 16'h0700, 16'h0033, '0, '0));
    iHaveData = 1'b1;
    pulse_en(3'b010, 16'h0088, '0, 16'h0321, '0, '0, '0, 1'b0);
    tick();
    tick();
    iHaveData = 1'b0;
    wait_drain("prio", 6);

    // Reset while a packet is held
    tx.r_ready = 1'b0;
    pulse_en(3'b101, 16'h0099, '0, '0, '0, '0, '0, 1'b1);
    pulse_en(3'b010, 16'h0001, '0, '0, '0, '0, '0, 1'b0);
    check("pre_rst_drop", 32'(drop_count), 32'd4);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_valid", 32'(tx.r_valid), 32'd0);
    check("arst_type", 32'(tx.rPacketType), 32'd7);
    check("arst_drop", 32'(drop_count), 32'd0);
    tick();
    nrst = 1'b1;
    tx.r_ready = 1'b1;
    repeat (3) tick();
    check("no_stale", 32'(tx.r_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
